// File: rtl/dbn_layer_result_collector_if.sv
// Handshake and read-port bundle between the sigmoid producer / next-layer reader
// (master) and the layer result collector (slave).
interface dbn_layer_result_collector_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 2
);
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              wt_reload;
    logic [ADDR_W-1:0] batch_idx;
    logic              layer_done;
    logic              layer_clr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    modport master (
        output res_valid, res_data, layer_clr, rd_en, rd_addr,
        input  res_ready, wt_reload, batch_idx, layer_done, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  res_valid, res_data, layer_clr, rd_en, rd_addr,
        output res_ready, wt_reload, batch_idx, layer_done, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/dbn_layer_result_collector.sv
// Collects DEPTH sigmoid result words per DBN layer and serves them back for reads.
// Optional macro DBN_RESULT_MIRROR0_EN adds the result_0 debug mirror of entry 0.
module dbn_layer_result_collector #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    dbn_layer_result_collector_if.slave  bus
`ifdef DBN_RESULT_MIRROR0_EN
    ,
    output logic [DATA_W-1:0]            result_0
`endif
);

    typedef enum logic {FILL, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wt_reload_q, wt_reload_d;
    logic              layer_done_q, layer_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Sized to the full address space so any rd_addr indexes safely; only DEPTH entries are used.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic res_ready;
    logic wr_fire;
    logic last_write;
    logic clr_fire;
    logic rd_ok;

    assign wr_fire    = bus.res_valid & res_ready;
    assign last_write = wr_fire & (wr_ptr_q == LAST_PTR);
    assign clr_fire   = (state_q == DONE) & bus.layer_clr;
    assign rd_ok      = bus.rd_en & (state_q == DONE) & ({1'b0, bus.rd_addr} < DEPTH_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (last_write)    state_d = DONE;
            DONE:    if (bus.layer_clr) state_d = FILL;
            default:                    state_d = FILL;
        endcase
    end

    always_comb begin
        res_ready = (state_q == FILL);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        wt_reload_d  = (wr_fire & ~last_write) | clr_fire;
        layer_done_d = (state_d == DONE);
        rd_valid_d   = rd_ok;
        rd_err_d     = bus.rd_en & ~rd_ok;
        rd_data_d    = rd_ok ? mem_q[bus.rd_addr] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            wt_reload_q  <= 1'b0;
            layer_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wt_reload_q  <= wt_reload_d;
            layer_done_q <= layer_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Contents survive reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem_q[wr_ptr_q] <= bus.res_data;
        end
    end

`ifdef DBN_RESULT_MIRROR0_EN
    logic [DATA_W-1:0] result_0_q, result_0_d;

    always_comb begin
        result_0_d = (wr_fire && (wr_ptr_q == '0)) ? bus.res_data : result_0_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_0_q <= '0;
        end else begin
            result_0_q <= result_0_d;
        end
    end

    assign result_0 = result_0_q;
`endif

    assign bus.res_ready  = res_ready;
    assign bus.wt_reload  = wt_reload_q;
    assign bus.batch_idx  = wr_ptr_q;
    assign bus.layer_done = layer_done_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_err     = rd_err_q;

endmodule
